// File: rtl/regbus_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regbus_master_if : command/response port and async register bus     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface regbus_master_if #(
  parameter int ADDR_W = 7
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic              cmd_wide_i;
  logic [ADDR_W-1:0] cmd_adr_i;
  logic [31:0]       cmd_dat_i;
  logic              rsp_valid_o;
  logic              rsp_err_o;
  logic [31:0]       rsp_dat_o;
  logic              busy_o;
  logic              cs_o;
  logic              we_o;
  logic              oe_o;
  logic [ADDR_W-1:0] adr_o;
  logic [15:0]       dat_o;
  logic [15:0]       dat_i;
  logic              dat_oe_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_wide_i, cmd_adr_i, cmd_dat_i, dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_dat_o, busy_o,
           cs_o, we_o, oe_o, adr_o, dat_o, dat_oe_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_wide_i, cmd_adr_i, cmd_dat_i, dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_dat_o, busy_o,
           cs_o, we_o, oe_o, adr_o, dat_o, dat_oe_o
  );
endinterface
`default_nettype wire

// File: rtl/regbus_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regbus_master : valid/ready commands to timed async register-bus     |
// | cycles; optional read-back verify via REGBUS_RDBACK_EN.  Rev 1.0     |
// +--------------------------------------------------------------------+
module regbus_master #(
  parameter int ADDR_W     = 7,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  regbus_master_if.master bus
);

  localparam int CNT_W = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCEPT = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] STROBE = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;

`ifdef REGBUS_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  logic [2:0]        state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic              beat, nxt_beat;
  logic              verify, nxt_verify;
  logic              more, nxt_more;
  logic              err, nxt_err;
  logic [31:0]       rdata, nxt_rdata;

  logic              cmd_we, cmd_wide;
  logic [ADDR_W-1:0] cmd_adr;
  logic [31:0]       cmd_dat;

  logic              ready, busy, rsp_valid, rsp_err;
  logic [31:0]       rsp_dat;
  logic              bus_cs, bus_we, bus_oe, bus_dat_oe;
  logic [ADDR_W-1:0] bus_adr;
  logic [15:0]       bus_dat;

  logic              accept, reading, phase_on, wr_beat;

  assign accept   = (state == IDLE) && bus.cmd_valid_i;
  assign reading  = !cmd_we || verify;
  assign phase_on = (nxt_state == SETUP) || (nxt_state == STROBE) || (nxt_state == HOLD);
  assign wr_beat  = cmd_we && !nxt_verify;

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt + 1'b1;
    nxt_beat   = beat;
    nxt_verify = verify;
    nxt_more   = more;
    nxt_err    = err;
    nxt_rdata  = rdata;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (accept) begin
          nxt_state  = ACCEPT;
          nxt_beat   = 1'b0;
          nxt_verify = 1'b0;
          nxt_more   = 1'b0;
          nxt_err    = 1'b0;
          nxt_rdata  = '0;
        end
      end
      ACCEPT: begin
        nxt_cnt = '0;
        // Wide accesses must start on the low half of a 32-bit pair
        if (cmd_wide && cmd_adr[1]) begin
          nxt_state = RESP;
          nxt_err   = 1'b1;
        end else begin
          nxt_state = SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          nxt_state = STROBE;
          nxt_cnt   = '0;
        end
      end
      STROBE: begin
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          nxt_state = HOLD;
          nxt_cnt   = '0;
          if (reading) begin
            if (beat) nxt_rdata[31:16] = bus.dat_i;
            else      nxt_rdata[15:0]  = bus.dat_i;
          end
          if (RDBACK && verify && (bus.dat_i != cmd_dat[15:0])) nxt_err = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          nxt_cnt = '0;
          if (cmd_wide && !beat) begin
            nxt_state = GAP;
            nxt_beat  = 1'b1;
            nxt_more  = 1'b1;
          end else if (RDBACK && cmd_we && !cmd_wide && !verify) begin
            nxt_state  = GAP;
            nxt_verify = 1'b1;
            nxt_more   = 1'b1;
          end else begin
            nxt_state = RESP;
          end
        end
      end
      RESP: begin
        nxt_state = GAP;
        nxt_cnt   = '0;
        nxt_more  = 1'b0;
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          nxt_cnt   = '0;
          nxt_state = more ? SETUP : IDLE;
          nxt_more  = 1'b0;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      beat       <= 1'b0;
      verify     <= 1'b0;
      more       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      cmd_we     <= 1'b0;
      cmd_wide   <= 1'b0;
      cmd_adr    <= '0;
      cmd_dat    <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_dat    <= '0;
      bus_cs     <= 1'b0;
      bus_we     <= 1'b0;
      bus_oe     <= 1'b0;
      bus_dat_oe <= 1'b0;
      bus_adr    <= '0;
      bus_dat    <= '0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      beat   <= nxt_beat;
      verify <= nxt_verify;
      more   <= nxt_more;
      err    <= nxt_err;
      rdata  <= nxt_rdata;
      if (accept) begin
        cmd_we   <= bus.cmd_we_i;
        cmd_wide <= bus.cmd_wide_i;
        cmd_adr  <= bus.cmd_adr_i;
        cmd_dat  <= bus.cmd_dat_i;
      end
      ready      <= (nxt_state == IDLE);
      busy       <= (nxt_state != IDLE);
      rsp_valid  <= (nxt_state == RESP);
      rsp_err    <= (nxt_state == RESP) && nxt_err;
      if (nxt_state == RESP) rsp_dat <= nxt_rdata;
      bus_cs     <= phase_on;
      bus_we     <= (nxt_state == STROBE) && wr_beat;
      bus_oe     <= (nxt_state == STROBE) && !wr_beat;
      bus_dat_oe <= phase_on && wr_beat;
      if ((nxt_state == SETUP) && (state != SETUP)) begin
        bus_adr <= nxt_beat ? (cmd_adr | ADDR_W'(2)) : cmd_adr;
        if (wr_beat) bus_dat <= nxt_beat ? cmd_dat[31:16] : cmd_dat[15:0];
      end
    end
  end

  // Ready is masked combinationally so it is low for the whole reset pulse
  assign bus.cmd_ready_o = ready && !rst_i;
  assign bus.busy_o      = busy;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_dat_o   = rsp_dat;
  assign bus.cs_o        = bus_cs;
  assign bus.we_o        = bus_we;
  assign bus.oe_o        = bus_oe;
  assign bus.dat_oe_o    = bus_dat_oe;
  assign bus.adr_o       = bus_adr;
  assign bus.dat_o       = bus_dat;

endmodule
`default_nettype wire

// File: doc/regbus_master.md
Name: regbus_master

Overview:
- Initiator for the FPGA 16-bit async register bus (cs/we/oe/adr/dat). Drives that bus toward the register-file slave, either inside the FPGA or across pins.
- Converts a single-cycle valid/ready command port into correctly timed bus cycles with setup, strobe, hold and gap phases.
- Wide (32-bit) accesses are split into the two-beat low/high sequence that the queue registers require.
- Used by the on-chip sequencer and by test benches to program and poll the timing generator.

Parameters:
- ADDR_W, 7, bus address width.
- SETUP_CYC, 1, cycles with cs/adr/dat valid before the strobe (≥1).
- STROBE_CYC, 4, cycles we_o or oe_o is held high (≥3, because the slave synchronises through two flops).
- HOLD_CYC, 1, cycles with cs/adr/dat held after the strobe drops (≥1).
- GAP_CYC, 2, idle cycles with everything deasserted between beats (≥2, so the slave sees a fresh rising edge).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_wide_i  in  1  1 = 32-bit two-beat access.
- cmd_adr_i  in  ADDR_W  word address.
- cmd_dat_i  in  32  write data; bits [15:0] only for narrow accesses.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_err_o  out  1  error flag, valid with rsp_valid_o.
- rsp_dat_o  out  32  read data; upper 16 bits are zero for narrow reads.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- cs_o  out  1  bus chip select.
- we_o  out  1  bus write strobe.
- oe_o  out  1  bus read strobe.
- adr_o  out  ADDR_W  bus address.
- dat_o  out  16  bus write data.
- dat_i  in  16  bus read data.
- dat_oe_o  out  1  write-data driver enable for the top-level tristate.

Behaviour:
- Clocking and reset:
  - One clock domain. All outputs are registered.
  - Reset is synchronous and active high: clk_i with rst_i.
  - Reset values: cs_o, we_o, oe_o, dat_oe_o, rsp_valid_o, rsp_err_o, busy_o = 0; adr_o, dat_o, rsp_dat_o = 0; cmd_ready_o = 1 after reset releases.
- Command acceptance:
  - cmd_ready_o is high only in IDLE and not in reset.
  - The command is captured on the edge where cmd_valid_i & cmd_ready_o.
  - Command inputs are ignored at all other times.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> (GAP -> SETUP for a second beat) or (RESP -> GAP -> IDLE).
  - SETUP: cs_o=1, adr_o valid. For writes, dat_o valid and dat_oe_o=1.
  - STROBE: we_o=1 (write) or oe_o=1 (read) for exactly STROBE_CYC cycles.
  - Read data: dat_i is sampled on the last STROBE cycle into the current half of rsp_dat_o.
  - HOLD: strobe=0, cs/adr/dat unchanged.
  - GAP: cs=0, dat_oe_o=0, adr_o and dat_o retain their values.
  - RESP: rsp_valid_o=1 for exactly one cycle, with rsp_dat_o and rsp_err_o valid.
- Beat order:
  - Narrow access: one beat at cmd_adr_i.
  - Wide write: beat 0 writes cmd_dat_i[15:0] to adr; beat 1 writes cmd_dat_i[31:16] to adr|2. The second write commits the 32-bit value.
  - Wide read: beat 0 reads adr into rsp_dat_o[15:0]; beat 1 reads adr|2 into rsp_dat_o[31:16].
- Wide command with cmd_adr_i[1]=1: no bus cycle is issued. The FSM goes straight to RESP with rsp_err_o=1 and rsp_dat_o=0.
- Latency with default parameters, acceptance at edge E:
  - cs_o high E+1..E+6.
  - Strobe high E+2..E+5.
  - rsp_valid_o at E+7 (narrow).
  - cmd_ready_o high again at E+10.
  - A wide access adds SETUP+STROBE+HOLD+GAP = 8 cycles.
- rst_i mid-access: all strobes drop on the next edge, the FSM returns to IDLE, and no response is produced.

Optional Feature:
- REGBUS_RDBACK_EN defined:
  - Every narrow write is followed by GAP, then a read beat to the same address.
  - rsp_err_o=1 if the read-back data ≠ written data.
  - rsp_dat_o returns the read-back value.
  - Wide writes are excluded, since the queue registers are not readable as written.
- REGBUS_RDBACK_EN undefined: no verify beat, and rsp_err_o is only set for a misaligned wide command.

Test Plan:
- Narrow write adr=0x04, data=0xA5A5 -> cs E+1..E+6, we E+2..E+5, dat_o=0xA5A5 while cs=1, rsp_valid at E+7 with err=0, ready at E+10.
- Narrow read adr=0x10, slave returns 0x1234 -> oe E+2..E+5, rsp_dat_o=0x00001234 at E+7.
- Wide write adr=0x08, data=0xDEADBEEF -> beat 0 writes 0xBEEF@0x08, 2-cycle gap, beat 1 writes 0xDEAD@0x0A, single rsp_valid at the end, slave queue = 0xDEADBEEF.
- Wide read adr=0x0A (misaligned) -> no cs assertion, rsp_valid at E+1 with err=1, ready at E+4.
- Reset asserted during the STROBE of a write -> we_o and cs_o are 0 on the next edge, no rsp_valid, ready=1 after release, a following write completes normally.
- With REGBUS_RDBACK_EN: write 0x00FF to a location the slave holds as 0x00F0 -> second beat is a read, rsp_err=1, rsp_dat_o=0x000000F0.
